tdm_demux_1_to_4: RTL

//  Receive end of a 4-slot time-division link: the transmit end multiplexes four channels

---
 rtl/tdm_demux_1_to_4_pkg.sv | 18 +
 rtl/tdm_demux_1_to_4_if.sv | 31 +++
 rtl/tdm_demux_1_to_4_slot_counter.sv | 26 ++
 rtl/tdm_demux_1_to_4.sv | 120 ++++++++++++
 4 files changed

// File: rtl/tdm_demux_1_to_4_pkg.sv
// Shared TDM link definitions for the receive (demux) and transmit (mux) ends.
package tdm_pkg;

   localparam int unsigned SLOTS = 4;

   typedef logic [1:0] slot_t;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_t;

   // Slot successor; 3 wraps back to 0.
   function automatic slot_t next_slot(input slot_t s);
      return s + 2'd1;
   endfunction

endpackage

// File: rtl/tdm_demux_1_to_4_if.sv
// Line-side inputs and per-channel outputs of the 4-slot TDM demultiplexer.
interface tdm_demux_1_to_4_if #(
   parameter int unsigned WIDTH = 1
);

   logic             EN;
   logic             SYNC;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Y0;
   logic [WIDTH-1:0] Y1;
   logic [WIDTH-1:0] Y2;
   logic [WIDTH-1:0] Y3;
   logic             S1;
   logic             S0;
   logic             VALID;
   logic             LOCK;
   logic             ERR;

   // Line receiver / consumer side
   modport master (
      output EN, SYNC, D,
      input  Y0, Y1, Y2, Y3, S1, S0, VALID, LOCK, ERR
   );

   // Demultiplexer side
   modport slave (
      input  EN, SYNC, D,
      output Y0, Y1, Y2, Y3, S1, S0, VALID, LOCK, ERR
   );

endinterface

// File: rtl/tdm_demux_1_to_4_slot_counter.sv
// 2-bit wrapping slot counter: clear to 0, load 1 on a frame marker, else count.
module tdm_slot_counter
   import tdm_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  en,
   input  logic  load,
   input  logic  clr,
   output slot_t cnt
);

   // Clear wins over load, load wins over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= 2'd1;
      end else if (en) begin
         cnt <= next_slot(cnt);
      end
   end

endmodule

// File: rtl/tdm_demux_1_to_4.sv
// Receive end of a 4-slot TDM link: locks to SYNC, captures each slot and
// presents all four channels once per completed frame with a VALID pulse.
module tdm_demux_1_to_4
   import tdm_pkg::*;
#(
   parameter int unsigned WIDTH    = 1,
   parameter int unsigned MAX_MISS = 2
) (
   input logic                  CLK,
   input logic                  RST_N,
   tdm_demux_1_to_4_if.slave    bus
);

   localparam int unsigned MISS_W = (MAX_MISS > 1) ? $clog2(MAX_MISS + 1) : 1;
   localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MAX_MISS - 1);

   tdm_state_t        state;
   slot_t             slot;
   logic [MISS_W-1:0] miss;
   logic [WIDTH-1:0]  shadow [SLOTS-1];
   logic [WIDTH-1:0]  y_q    [SLOTS];
   logic              valid_q;
   logic              lock_q;
   logic              err_q;

   logic              miss_hit;
   logic              cnt_clr;
   logic              cnt_load;
   logic              cnt_inc;

   assign miss_hit = (miss == MISS_LAST);

   // Any SYNC beat restarts the frame at slot 1 (HUNT lock, normal slot 0, or
   // resync); a missed marker that exhausts the budget returns the counter to 0.
   assign cnt_clr  = bus.EN && (state == LOCKED) && (slot == 2'd0) && !bus.SYNC && miss_hit;
   assign cnt_load = bus.EN && bus.SYNC;
   assign cnt_inc  = bus.EN && (state == LOCKED);

   tdm_slot_counter u_slot_counter (
      .clk   (CLK),
      .rst_n (RST_N),
      .en    (cnt_inc),
      .load  (cnt_load),
      .clr   (cnt_clr),
      .cnt   (slot)
   );

   // Lock FSM, miss counter, shadow capture and registered channel outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= HUNT;
         miss    <= '0;
         valid_q <= 1'b0;
         lock_q  <= 1'b0;
         err_q   <= 1'b0;
         for (int unsigned i = 0; i < SLOTS - 1; i++) shadow[i] <= '0;
         for (int unsigned i = 0; i < SLOTS; i++)     y_q[i]    <= '0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         if (bus.EN) begin
            case (state)
               HUNT: begin
                  if (bus.SYNC) begin
                     shadow[0] <= bus.D;
                     state     <= LOCKED;
                     lock_q    <= 1'b1;
                     miss      <= '0;
                  end
               end
               LOCKED: begin
                  if (slot == 2'd0) begin
                     shadow[0] <= bus.D;
                     if (bus.SYNC) begin
                        miss <= '0;
                     end else if (miss_hit) begin
                        state  <= HUNT;
                        lock_q <= 1'b0;
                        miss   <= '0;
                     end else begin
                        miss <= miss + 1'b1;
                     end
                  end else if (bus.SYNC) begin
                     err_q     <= 1'b1;
                     shadow[0] <= bus.D;
                     miss      <= '0;
                  end else begin
                     case (slot)
                        2'd1: shadow[1] <= bus.D;
                        2'd2: shadow[2] <= bus.D;
                        default: begin
                           y_q[0]  <= shadow[0];
                           y_q[1]  <= shadow[1];
                           y_q[2]  <= shadow[2];
                           y_q[3]  <= bus.D;
                           valid_q <= 1'b1;
                        end
                     endcase
                  end
               end
               default: begin
                  state  <= HUNT;
                  lock_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.Y0    = y_q[0];
   assign bus.Y1    = y_q[1];
   assign bus.Y2    = y_q[2];
   assign bus.Y3    = y_q[3];
   assign bus.S1    = slot[1];
   assign bus.S0    = slot[0];
   assign bus.VALID = valid_q;
   assign bus.LOCK  = lock_q;
   assign bus.ERR   = err_q;

endmodule
